// File: rtl/deserialize_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
package deserialize_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width: never narrower than one bit, even for WIDTH=1.
    function automatic int cnt_w(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/deserialize_obuf.sv
// One-entry valid/ready output register; flags a completed word that cannot be stored.
module deserialize_obuf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    output logic             drop
);
    logic [WIDTH-1:0] pout_reg;
    logic             pout_valid_reg;
    logic             accept_load;

    // A full buffer may still take a new word if it is drained on the same edge.
    assign accept_load = load && (!pout_valid_reg || ready);
    assign drop        = load && pout_valid_reg && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pout_reg       <= '0;
            pout_valid_reg <= 1'b0;
        end else if (accept_load) begin
            pout_reg       <= data;
            pout_valid_reg <= 1'b1;
        end else if (pout_valid_reg && ready) begin
            pout_valid_reg <= 1'b0;
        end
    end

    assign pout       = pout_reg;
    assign pout_valid = pout_valid_reg;

endmodule

// File: rtl/deserialize.sv
// Serial-to-parallel receiver with start-of-frame alignment and a one-word output buffer.
module deserialize
    import deserialize_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_sof,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             framing_err
);
    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] word_base;
    logic [WIDTH-1:0] shift_next;
    logic             overrun_reg;
    logic             framing_err_reg;
    logic             accept;
    logic             complete;
    logic             drop;

    // A start-of-frame always restarts the word at bit 0, discarding any partial bits.
    always_comb begin
        accept    = sin_valid && (state_reg == SHIFT || sin_sof);
        cnt_base  = sin_sof ? '0 : cnt_reg;
        word_base = (cnt_base == '0) ? '0 : shift_reg;
        complete  = accept && (cnt_base == CNT_LAST);
        cnt_next  = complete ? '0 : cnt_base + CW'(1);
    end

    generate
        if (WIDTH == 1) begin : g_w1
            assign shift_next = sin;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign shift_next = {word_base[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign shift_next = {sin, word_base[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= HUNT;
            cnt_reg         <= '0;
            shift_reg       <= '0;
            overrun_reg     <= 1'b0;
            framing_err_reg <= 1'b0;
        end else begin
            framing_err_reg <= accept && sin_sof && (state_reg == SHIFT) && (cnt_reg != '0);
            overrun_reg     <= overrun_reg | drop;
            if (accept) begin
                state_reg <= SHIFT;
                cnt_reg   <= cnt_next;
                shift_reg <= shift_next;
            end
        end
    end

    deserialize_obuf #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .data       (shift_next),
        .ready      (pout_ready),
        .pout       (pout),
        .pout_valid (pout_valid),
        .drop       (drop)
    );

    assign overrun     = overrun_reg;
    assign framing_err = framing_err_reg;

endmodule
